// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU memory port and mem_responder.
// master = CPU side (drives the request), slave = responder side.
interface mem_responder_if #(
  parameter int ADDR_BITS = 14
);
  logic                 req;
  logic [ADDR_BITS-1:0] addr;
  logic [3:0]           write_en;
  logic [31:0]          data_in;
  logic [31:0]          data_out;
  logic                 sync;
  logic                 err;

  modport master (
    output req, addr, write_en, data_in,
    input  data_out, sync, err
  );

  modport slave (
    input  req, addr, write_en, data_in,
    output data_out, sync, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: slow memory model behind the CPU's stalling memory port.
// Accepts one request, stalls the CPU (sync) for LATENCY+1 cycles, then
// commits a byte-enabled write / registered read into a word array.
// Optional feature macro: MEM_RESP_OOR_ERR_EN -- addresses at or beyond DEPTH
// return 32'hDEAD_BEEF with a one-cycle err pulse and drop the write. When the
// macro is undefined the array index wraps (addr mod DEPTH) and err is tied 0.
// DEPTH must be a power of two (>= 2); LATENCY must be 1..15.
module mem_responder #(
  parameter int ADDR_BITS = 14,
  parameter int DEPTH     = 16384,
  parameter int LATENCY   = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int         IDX_BITS = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           we_q;
  logic [31:0]          data_out_q;
`ifdef MEM_RESP_OOR_ERR_EN
  logic                 err_q;
`endif

  // Word array and the word read out of it at accept time.
  logic [31:0]          mem [DEPTH];
  logic [31:0]          rdata_q;
  logic [31:0]          merged;

  logic                 accept;
  logic                 commit;
  logic                 oor;
  logic                 write_ok;
  logic [IDX_BITS-1:0]  rd_idx;
  logic [IDX_BITS-1:0]  wr_idx;
  logic                 unused_addr_hi;

  assign accept = (state == IDLE) && bus.req;
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // The array is indexed by the low address bits; upper bits either wrap
  // silently or flag an out-of-range access.
  assign rd_idx = bus.addr[IDX_BITS-1:0];
  assign wr_idx = addr_q[IDX_BITS-1:0];

  // Upper address bits are only consumed by the range check.
  assign unused_addr_hi = ^{addr_q, bus.addr};

`ifdef MEM_RESP_OOR_ERR_EN
  generate
    if (IDX_BITS < ADDR_BITS) begin : g_oor
      assign oor = |addr_q[ADDR_BITS-1:IDX_BITS];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate
`else
  assign oor = 1'b0;
`endif

  assign write_ok = commit && !oor;

  // Write-first merge: enabled lanes take the new data, others keep the old word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = we_q[gi] ? wdata_q[8*gi +: 8] : rdata_q[8*gi +: 8];
    end
  endgenerate

  // Array port: registered read at accept, byte-enabled write at commit.
  // No reset here: contents survive reset, and an aborted access never
  // reaches commit because the FSM state is cleared asynchronously.
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_q <= mem[rd_idx];
    end
    if (write_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (we_q[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Control FSM: capture request, count busy cycles, present the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 4'd0;
      data_out_q <= 32'd0;
`ifdef MEM_RESP_OOR_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
`ifdef MEM_RESP_OOR_ERR_EN
      // err is a single-cycle pulse aligned with RESP.
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.data_in;
            we_q    <= bus.write_en;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
`ifdef MEM_RESP_OOR_ERR_EN
            if (oor) begin
              data_out_q <= 32'hDEAD_BEEF;
              err_q      <= 1'b1;
            end else begin
              data_out_q <= merged;
            end
`else
            data_out_q <= merged;
`endif
          end
        end
        RESP: begin
          // Requests seen here wait for the next IDLE cycle.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall: follows req while idle so the CPU holds from the request cycle on.
  assign bus.sync     = (state == IDLE) ? bus.req : (state == BUSY);
  assign bus.data_out = data_out_q;
`ifdef MEM_RESP_OOR_ERR_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: one full-depth instance for the main
// access/timing checks and one DEPTH=1024 instance for the out-of-range case.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_responder_if #(.ADDR_BITS(14)) bus  ();
  mem_responder_if #(.ADDR_BITS(14)) sbus ();

  mem_responder #(.ADDR_BITS(14), .DEPTH(16384), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_responder #(.ADDR_BITS(14), .DEPTH(1024), .LATENCY(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic [13:0] a,
                       input logic [3:0] we, input logic [31:0] d);
    if (sel) begin
      sbus.req = r; sbus.addr = a; sbus.write_en = we; sbus.data_in = d;
    end else begin
      bus.req = r; bus.addr = a; bus.write_en = we; bus.data_in = d;
    end
  endtask

  function automatic logic cur_sync(input bit sel);
    return sel ? sbus.sync : bus.sync;
  endfunction

  function automatic logic [31:0] cur_data(input bit sel);
    return sel ? sbus.data_out : bus.data_out;
  endfunction

  function automatic logic cur_err(input bit sel);
    return sel ? sbus.err : bus.err;
  endfunction

  // Called at posedge+1 with the responder idle. Returns the number of cycles
  // sync was high and the data_out/err seen in the RESP cycle. Returns at
  // posedge+1 of the IDLE cycle after RESP with req dropped.
  task automatic access(input bit sel, input logic [13:0] a, input logic [3:0] we,
                        input logic [31:0] d, input bit disturb,
                        output int hi, output logic [31:0] q, output logic e);
    hi = 0;
    drive(sel, 1'b1, a, we, d);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!cur_sync(sel)) break;
      hi++;
      @(posedge clk); #1;
      if (disturb && i == 0) drive(sel, 1'b0, 14'h020, 4'h0, 32'h0);
    end
    q = cur_data(sel);
    e = cur_err(sel);
    drive(sel, 1'b0, a, 4'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          hi;
    logic [31:0] q;
    logic        e;
    logic [7:0]  pat;

    rst = 1'b0;
    drive(1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 14'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_data_out", bus.data_out, 32'h0);
    check_eq("reset_sync", {31'd0, bus.sync}, 32'h0);
    check_eq("reset_err", {31'd0, bus.err}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Known value at 0x020 so "untouched" can be checked later.
    access(1'b0, 14'h020, 4'hF, 32'h0BAD_F00D, 1'b0, hi, q, e);
    check_eq("pre_w020_data", q, 32'h0BAD_F00D);

    // 1: full-word write.
    access(1'b0, 14'h010, 4'hF, 32'h1234_5678, 1'b0, hi, q, e);
    check_eq("t1_sync_cycles", hi, 32'd3);
    check_eq("t1_data_out", q, 32'h1234_5678);
    check_eq("t1_hold_idle", bus.data_out, 32'h1234_5678);
    check_eq("t1_idle_sync", {31'd0, bus.sync}, 32'h0);

    // 2: read back.
    access(1'b0, 14'h010, 4'h0, 32'hFFFF_FFFF, 1'b0, hi, q, e);
    check_eq("t2_sync_cycles", hi, 32'd3);
    check_eq("t2_read", q, 32'h1234_5678);

    // 3: single-lane write, then read.
    access(1'b0, 14'h010, 4'b0010, 32'h0000_AB00, 1'b0, hi, q, e);
    check_eq("t3_merge_resp", q, 32'h1234_AB78);
    access(1'b0, 14'h010, 4'h0, 32'h0, 1'b0, hi, q, e);
    check_eq("t3_read", q, 32'h1234_AB78);

    // 4: addr changed and req dropped mid-BUSY.
    access(1'b0, 14'h010, 4'hF, 32'hCAFE_0001, 1'b1, hi, q, e);
    check_eq("t4_sync_cycles", hi, 32'd3);
    check_eq("t4_data_out", q, 32'hCAFE_0001);
    access(1'b0, 14'h010, 4'h0, 32'h0, 1'b0, hi, q, e);
    check_eq("t4_read_010", q, 32'hCAFE_0001);
    access(1'b0, 14'h020, 4'h0, 32'h0, 1'b0, hi, q, e);
    check_eq("t4_read_020", q, 32'h0BAD_F00D);

    // Back-to-back reads with req held: 3 stall cycles, 1 RESP, repeat.
    drive(1'b0, 1'b1, 14'h010, 4'h0, 32'h0);
    pat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      pat = {pat[6:0], bus.sync};
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 14'h010, 4'h0, 32'h0);
    check_eq("b2b_sync_pattern", {24'd0, pat}, 32'h0000_00EE);
    check_eq("b2b_data_out", bus.data_out, 32'hCAFE_0001);
    @(posedge clk); #1;

    // 5: reset in the middle of a write; the write must be discarded.
    access(1'b0, 14'h030, 4'hF, 32'hAAAA_AAAA, 1'b0, hi, q, e);
    check_eq("t5_pre_write", q, 32'hAAAA_AAAA);
    drive(1'b0, 1'b1, 14'h030, 4'hF, 32'h5555_5555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 14'h030, 4'h0, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_sync", {31'd0, bus.sync}, 32'h0);
    check_eq("t5_rst_data_out", bus.data_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 14'h030, 4'h0, 32'h0, 1'b0, hi, q, e);
    check_eq("t5_read_030", q, 32'hAAAA_AAAA);

    // 6: DEPTH=1024 instance, address 0x400.
    access(1'b1, 14'h000, 4'hF, 32'h1111_1111, 1'b0, hi, q, e);
    check_eq("t6_pre_w000", q, 32'h1111_1111);
    access(1'b1, 14'h400, 4'hF, 32'h2222_2222, 1'b0, hi, q, e);
    check_eq("t6_sync_cycles", hi, 32'd3);
`ifdef MEM_RESP_OOR_ERR_EN
    check_eq("t6_oor_data", q, 32'hDEAD_BEEF);
    check_eq("t6_oor_err", {31'd0, e}, 32'h1);
    check_eq("t6_err_pulse_end", {31'd0, sbus.err}, 32'h0);
    access(1'b1, 14'h000, 4'h0, 32'h0, 1'b0, hi, q, e);
    check_eq("t6_read_000", q, 32'h1111_1111);
`else
    check_eq("t6_wrap_data", q, 32'h2222_2222);
    check_eq("t6_wrap_err", {31'd0, e}, 32'h0);
    access(1'b1, 14'h000, 4'h0, 32'h0, 1'b0, hi, q, e);
    check_eq("t6_read_000", q, 32'h2222_2222);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
